// File: rtl/calc_pkg.sv
// Shared types and key-code constants for the keypad calculator front end.
package calc_pkg;

    typedef enum logic [3:0] {
        NUM1,
        CONV1,
        WR1,
        OPSEL,
        WR_OP,
        NUM2,
        CONV2,
        WR2,
        RUN,
        FETCH,
        DISPLAY
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } opcode_t;

    localparam logic [4:0] KEY_RECALL = 5'd10;
    localparam logic [4:0] KEY_BKSP   = 5'd11;
    localparam logic [4:0] KEY_ENTER  = 5'd12;
    localparam logic [4:0] KEY_CLEAR  = 5'd13;

    function automatic logic is_digit(input logic [4:0] code);
        return code <= 5'd9;
    endfunction

    // Operator keys occupy 16..19, so the opcode is simply the low two bits.
    function automatic logic is_operator(input logic [4:0] code);
        return code[4:2] == 3'b100;
    endfunction

endpackage

// File: rtl/bcd_serial_conv.sv
// Serial BCD-to-binary converter: one digit per cycle, MSB first, DIGITS cycles per run.
module bcd_serial_conv
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start_i,
    input  logic [3:0]    digit_i,
    output logic [IW-1:0] idx_o,
    output logic          done_o,
    output logic [31:0]   value_o
);

    logic          active_q;
    logic [IW-1:0] cnt_q;
    logic [31:0]   acc_q;
    logic [31:0]   acc_d;

    // acc*10 as shift-add keeps the arithmetic naturally mod 2^32.
    assign acc_d   = (acc_q << 3) + (acc_q << 1) + 32'(digit_i);
    assign idx_o   = cnt_q;
    assign done_o  = active_q && (cnt_q == IW'(DIGITS - 1));
    assign value_o = acc_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
        end else if (active_q) begin
            if (done_o) begin
                active_q <= 1'b0;
                cnt_q    <= '0;
                acc_q    <= '0;
            end else begin
                cnt_q <= cnt_q + IW'(1);
                acc_q <= acc_d;
            end
        end
    end

endmodule

// File: rtl/keypad_calc_ctrl.sv
// Keypad front end: collects two BCD operands and an opcode, hands them to the CPU
// through memory-mapped writes, runs the CPU, then fetches and displays the result.
module keypad_calc_ctrl
    import calc_pkg::*;
#(
    parameter int          DIGITS     = 4,
    parameter logic [31:0] ADDR_OP1   = 32'd220,
    parameter logic [31:0] ADDR_OP2   = 32'd240,
    parameter logic [31:0] ADDR_OPC   = 32'd260,
    parameter logic [31:0] ADDR_RES   = 32'd280,
    parameter logic [31:0] ADDR_IDLE  = 32'd320,
    parameter logic [31:0] DONE_INSTR = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  key_valid,
    input  logic [4:0]            key_code,
    input  logic [31:0]           instruction,
    input  logic [31:0]           data_in,
    output logic [31:0]           address,
    output logic [31:0]           data_out,
    output logic                  fpga_en,
    output logic                  fpga_write,
    output logic                  cpu_en,
    output logic                  nrst_fpga,
    output logic [4*DIGITS-1:0]   disp,
    output logic [1:0]            disp_sel,
    output logic                  ovf,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] DISP_MASK64 = (64'd1 << BW) - 64'd1;
    localparam logic [31:0] DISP_MASK   = DISP_MASK64[31:0];

    state_t        state_q, state_d;
    logic [BW-1:0] buf1_q, buf1_d, buf2_q, buf2_d;
    logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    opcode_t       opcode_q, opcode_d;
    logic          opc_valid_q, opc_valid_d;
    logic [31:0]   op1_q, op1_d, op2_q, op2_d;
    logic [31:0]   result_q, result_d;
    logic          ovf_q, ovf_d;

    logic [BW-1:0] act_buf, edit_buf;
    logic [CW-1:0] act_cnt, edit_cnt;
    logic          clear_req;

    logic          conv_start;
    logic [3:0]    conv_digit;
    logic [IW-1:0] conv_idx;
    logic          conv_done;
    logic [31:0]   conv_value;

    bcd_serial_conv #(
        .DIGITS (DIGITS),
        .IW     (IW)
    ) u_conv (
        .clk     (clk),
        .nrst    (nrst),
        .start_i (conv_start),
        .digit_i (conv_digit),
        .idx_o   (conv_idx),
        .done_o  (conv_done),
        .value_o (conv_value)
    );

    // The same edit logic serves whichever operand buffer is currently active.
    always_comb begin
        act_buf  = (state_q == NUM2 || state_q == CONV2) ? buf2_q : buf1_q;
        act_cnt  = (state_q == NUM2 || state_q == CONV2) ? cnt2_q : cnt1_q;
        edit_buf = act_buf;
        edit_cnt = act_cnt;
        if (key_valid) begin
            if (is_digit(key_code) && act_cnt != CW'(DIGITS)) begin
                edit_buf = (act_buf << 4) | BW'(key_code[3:0]);
                edit_cnt = act_cnt + CW'(1);
            end else if (key_code == KEY_BKSP && act_cnt != '0) begin
                edit_buf = act_buf >> 4;
                edit_cnt = act_cnt - CW'(1);
            end
        end
        conv_digit = 4'(act_buf >> (4 * (DIGITS - 1 - int'(conv_idx))));
        conv_start = key_valid && key_code == KEY_ENTER &&
                     (state_q == NUM1 || state_q == NUM2);
    end

    always_comb begin
        state_d     = state_q;
        buf1_d      = buf1_q;
        buf2_d      = buf2_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        opcode_d    = opcode_q;
        opc_valid_d = opc_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        clear_req   = 1'b0;

        case (state_q)
            NUM1: begin
                buf1_d = edit_buf;
                cnt1_d = edit_cnt;
                if (key_valid) begin
                    if (key_code == KEY_ENTER) begin
                        state_d = CONV1;
                    end else if (key_code == KEY_RECALL) begin
                        op1_d   = result_q;
                        state_d = WR1;
                    end else if (key_code == KEY_CLEAR) begin
                        clear_req = 1'b1;
                    end
                end
            end
            CONV1: begin
                if (conv_done) begin
                    op1_d   = conv_value;
                    state_d = WR1;
                end
            end
            WR1: state_d = OPSEL;
            OPSEL: begin
                if (key_valid) begin
                    if (is_operator(key_code)) begin
                        opcode_d    = opcode_t'(key_code[1:0]);
                        opc_valid_d = 1'b1;
                    end else if (key_code == KEY_ENTER && opc_valid_q) begin
                        state_d = WR_OP;
                    end else if (key_code == KEY_CLEAR) begin
                        clear_req = 1'b1;
                        state_d   = NUM1;
                    end
                end
            end
            WR_OP: state_d = NUM2;
            NUM2: begin
                buf2_d = edit_buf;
                cnt2_d = edit_cnt;
                if (key_valid) begin
                    if (key_code == KEY_ENTER) begin
                        state_d = CONV2;
                    end else if (key_code == KEY_CLEAR) begin
                        clear_req = 1'b1;
                        state_d   = NUM1;
                    end
                end
            end
            CONV2: begin
                if (conv_done) begin
                    op2_d   = conv_value;
                    state_d = WR2;
                end
            end
            WR2: state_d = RUN;
            RUN: begin
                if (instruction == DONE_INSTR) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                result_d = data_in;
                ovf_d    = |(data_in & ~DISP_MASK);
                state_d  = DISPLAY;
            end
            DISPLAY: begin
                if (key_valid && key_code == KEY_ENTER) begin
                    clear_req = 1'b1;
                    ovf_d     = 1'b0;
                    state_d   = NUM1;
                end
            end
            default: state_d = NUM1;
        endcase

        // A fresh calculation starts with empty entry state; the last result is kept for recall.
        if (clear_req) begin
            buf1_d      = '0;
            buf2_d      = '0;
            cnt1_d      = '0;
            cnt2_d      = '0;
            opcode_d    = OP_ADD;
            opc_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= NUM1;
            buf1_q      <= '0;
            buf2_q      <= '0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            opcode_q    <= OP_ADD;
            opc_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf1_q      <= buf1_d;
            buf2_q      <= buf2_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            opcode_q    <= opcode_d;
            opc_valid_q <= opc_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        address    = ADDR_IDLE;
        data_out   = '0;
        fpga_en    = 1'b1;
        fpga_write = 1'b0;
        cpu_en     = 1'b0;
        nrst_fpga  = 1'b1;
        disp       = '0;
        disp_sel   = 2'd0;
        busy       = 1'b1;
        ovf        = ovf_q;

        case (state_q)
            NUM1: begin
                disp = buf1_q;
                busy = 1'b0;
            end
            CONV1: disp = buf1_q;
            WR1: begin
                disp       = buf1_q;
                fpga_write = 1'b1;
                address    = ADDR_OP1;
                data_out   = op1_q;
            end
            OPSEL: begin
                disp     = BW'(opcode_q);
                disp_sel = 2'd1;
                busy     = 1'b0;
            end
            WR_OP: begin
                disp       = BW'(opcode_q);
                disp_sel   = 2'd1;
                fpga_write = 1'b1;
                address    = ADDR_OPC;
                data_out   = 32'(opcode_q);
            end
            NUM2: begin
                disp     = buf2_q;
                disp_sel = 2'd2;
                busy     = 1'b0;
            end
            CONV2: begin
                disp     = buf2_q;
                disp_sel = 2'd2;
            end
            WR2: begin
                disp       = buf2_q;
                disp_sel   = 2'd2;
                fpga_write = 1'b1;
                address    = ADDR_OP2;
                data_out   = op2_q;
            end
            RUN: begin
                disp_sel = 2'd3;
                fpga_en  = 1'b0;
                cpu_en   = 1'b1;
            end
            FETCH: begin
                disp_sel = 2'd3;
                address  = ADDR_RES;
            end
            DISPLAY: begin
                disp      = BW'(result_q);
                disp_sel  = 2'd3;
                address   = ADDR_RES;
                nrst_fpga = 1'b0;
                busy      = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_keypad_calc_ctrl.sv
// Directed bench for keypad_calc_ctrl: entry editing, conversion timing, full CPU handshake, overflow, reset.
module tb_keypad_calc_ctrl;
    import calc_pkg::*;

    localparam int DIGITS = 4;
    localparam logic [31:0] DONE = 32'hFFFF_FFFF;

    logic                clk = 1'b0;
    logic                nrst = 1'b0;
    logic                key_valid = 1'b0;
    logic [4:0]          key_code = '0;
    logic [31:0]         instruction = '0;
    logic [31:0]         data_in = '0;
    logic [31:0]         address, data_out;
    logic                fpga_en, fpga_write, cpu_en, nrst_fpga, ovf, busy;
    logic [4*DIGITS-1:0] disp;
    logic [1:0]          disp_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_calc_ctrl #(.DIGITS(DIGITS)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .instruction (instruction),
        .data_in     (data_in),
        .address     (address),
        .data_out    (data_out),
        .fpga_en     (fpga_en),
        .fpga_write  (fpga_write),
        .cpu_en      (cpu_en),
        .nrst_fpga   (nrst_fpga),
        .disp        (disp),
        .disp_sel    (disp_sel),
        .ovf         (ovf),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic [4:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic check_write(input string tag, input logic [31:0] addr, input logic [31:0] val);
        check({tag, "_we"}, 32'(fpga_write), 32'd1);
        check({tag, "_addr"}, address, addr);
        check({tag, "_data"}, data_out, val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Outputs while reset is held
        #1;
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_fpga_en", 32'(fpga_en), 32'd1);
        check("rst_write", 32'(fpga_write), 32'd0);
        check("rst_nrst_fpga", 32'(nrst_fpga), 32'd1);
        check("rst_addr", address, 32'd320);
        check("rst_data", data_out, 32'd0);
        check("rst_disp", 32'(disp), 32'd0);
        check("rst_disp_sel", 32'(disp_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        tick();
        nrst = 1'b1;
        tick();

        // Full buffer ignores the fifth digit; backspace stops at empty
        press(5'd9); press(5'd9); press(5'd9); press(5'd9); press(5'd5);
        check("full_buf", 32'(disp), 32'h9999);
        repeat (5) press(KEY_BKSP);
        check("bksp_empty", 32'(disp), 32'h0);
        press(5'd1); press(5'd2); press(5'd3); press(5'd4); press(5'd5);
        check("no_underflow", 32'(disp), 32'h1234);
        press(KEY_CLEAR);
        check("clear_num1", 32'(disp), 32'h0);

        // 1,2,3,enter -> write 123 to 220 four cycles after CONV1 entry
        press(5'd1); press(5'd2); press(5'd3);
        check("buf_123", 32'(disp), 32'h0123);
        press(KEY_ENTER);
        check("conv_busy", 32'(busy), 32'd1);
        ticks(3);
        check("conv_no_we", 32'(fpga_write), 32'd0);
        tick();
        check_write("wr1_123", 32'd220, 32'd123);
        tick();
        check("opsel_sel", 32'(disp_sel), 32'd1);
        check("opsel_busy", 32'(busy), 32'd0);
        press(KEY_ENTER);
        check("enter_no_opc", 32'(fpga_write), 32'd0);
        check("still_opsel", 32'(disp_sel), 32'd1);
        press(5'd16);
        press(KEY_ENTER);
        check_write("wr_op_add", 32'd260, 32'd0);
        tick();
        check("num2_sel", 32'(disp_sel), 32'd2);
        press(5'd4);
        check("num2_buf", 32'(disp), 32'h0004);
        press(KEY_CLEAR);
        check("clr_sel", 32'(disp_sel), 32'd0);
        check("clr_buf1", 32'(disp), 32'h0);
        press(5'd5);
        check("clr_fresh", 32'(disp), 32'h0005);
        press(KEY_CLEAR);

        // Full flow 7 + 5, CPU done after 10 cycles, result 12
        press(5'd7);
        press(KEY_ENTER);
        ticks(4);
        check_write("wr1_7", 32'd220, 32'd7);
        tick();
        press(5'd16);
        press(KEY_ENTER);
        check_write("wr_op_0", 32'd260, 32'd0);
        tick();
        press(5'd5);
        press(KEY_ENTER);
        ticks(4);
        check_write("wr2_5", 32'd240, 32'd5);
        data_in = 32'd12;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("run_cpu_en", 32'(cpu_en), 32'd1);
            if (i == 0) begin
                check("run_fpga_en", 32'(fpga_en), 32'd0);
                check("run_addr", address, 32'd320);
            end
            if (i == 9) instruction = DONE;
            tick();
        end
        instruction = '0;
        check("fetch_cpu_en", 32'(cpu_en), 32'd0);
        check("fetch_addr", address, 32'd280);
        tick();
        check("disp_12", 32'(disp), 32'h000C);
        check("disp_ovf0", 32'(ovf), 32'd0);
        check("disp_nrst", 32'(nrst_fpga), 32'd0);
        check("disp_sel3", 32'(disp_sel), 32'd3);
        check("disp_busy", 32'(busy), 32'd0);
        press(KEY_ENTER);
        check("back_sel", 32'(disp_sel), 32'd0);
        check("back_nrst", 32'(nrst_fpga), 32'd1);

        // Recall 12, empty op2 gives 0, done on first RUN cycle, overflow result
        press(KEY_RECALL);
        check_write("recall_12", 32'd220, 32'd12);
        tick();
        press(5'd17);
        press(KEY_ENTER);
        check_write("wr_op_sub", 32'd260, 32'd1);
        tick();
        press(KEY_ENTER);
        ticks(4);
        check_write("wr2_zero", 32'd240, 32'd0);
        instruction = DONE;
        data_in = 32'h0001_0000;
        tick();
        check("run1_cpu_en", 32'(cpu_en), 32'd1);
        tick();
        check("fetch1_addr", address, 32'd280);
        tick();
        instruction = '0;
        check("ovf_disp", 32'(disp), 32'h0);
        check("ovf_flag", 32'(ovf), 32'd1);
        press(KEY_ENTER);
        press(KEY_RECALL);
        check_write("recall_big", 32'd220, 32'h0001_0000);
        tick();

        // Reset asserted in the middle of RUN
        press(5'd18);
        press(KEY_ENTER);
        tick();
        press(5'd3);
        press(KEY_ENTER);
        ticks(4);
        tick();
        ticks(3);
        check("mid_run_cpu", 32'(cpu_en), 32'd1);
        nrst = 1'b0;
        #1;
        check("arst_cpu_en", 32'(cpu_en), 32'd0);
        check("arst_fpga_en", 32'(fpga_en), 32'd1);
        check("arst_sel", 32'(disp_sel), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_addr", address, 32'd320);
        #2;
        nrst = 1'b1;
        tick();
        check("post_rst_disp", 32'(disp), 32'h0);
        press(KEY_RECALL);
        check_write("recall_rst", 32'd220, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_calc_ctrl.md
KEYPAD_CALC_CTRL -- requirements
Module: keypad_calc_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, range 1..8: decimal digits per operand buffer.
REQ-002 SHALL have parameters ADDR_OP1 = 220, ADDR_OP2 = 240, ADDR_OPC = 260, ADDR_RES = 280, ADDR_IDLE = 320: 32-bit memory-mapped word addresses.
REQ-003 SHALL have parameter DONE_INSTR, default 32'hFFFF_FFFF: the instruction word that marks CPU completion.
REQ-004 SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  system clock; all state changes on the rising edge.
- nrst  in  1  asynchronous active-low reset.
REQ-005 SHALL have the following remaining ports:
- key_valid  in  1  one-cycle, already-synchronised key pulse.
- key_code  in  5  key code: 0-9 digit, 10 recall, 11 backspace, 12 enter, 13 clear, 16-19 operator.
- instruction  in  32  current CPU instruction.
- data_in  in  32  memory read data.
- address  out  32  memory address.
- data_out  out  32  memory write data.
- fpga_en  out  1  FPGA owns the bus.
- fpga_write  out  1  write strobe.
- cpu_en  out  1  CPU run enable.
- nrst_fpga  out  1  active-low CPU reset request.
- disp  out  4*DIGITS  nibble display field, digit 0 in the LSBs.
- disp_sel  out  2  field shown: 0 = op1, 1 = opcode, 2 = op2, 3 = result.
- ovf  out  1  result exceeds the display width.
- busy  out  1  high outside the NUM1, OPSEL, NUM2 and DISPLAY states.

Function
REQ-006 SHALL implement the states NUM1, CONV1, WR1, OPSEL, WR_OP, NUM2, CONV2, WR2, RUN, FETCH, DISPLAY.
REQ-007 SHALL, in NUM1 and NUM2, shift a digit key in at the LSB of the BCD buffer (count+1); when count == DIGITS, digit keys are ignored (no shift-out).
REQ-008 SHALL, on backspace, shift the buffer right one digit (count-1); backspace at count 0 is ignored.
REQ-009 SHALL, on enter in NUM1 or NUM2, go to CONV1 or CONV2 respectively; enter at count 0 yields operand 0.
REQ-010 SHALL convert in CONVx MSB-first, one digit per cycle (acc = acc*10 + digit, 32-bit, mod 2^32), taking exactly DIGITS cycles, then go to WRx.
REQ-011 SHALL, in WR1, WR_OP and WR2, assert fpga_write for one cycle with address set to ADDR_OP1, ADDR_OPC or ADDR_OP2 and data_out set to the value; the next states are OPSEL, NUM2 and RUN respectively.
REQ-012 SHALL, in OPSEL, latch opcode = key_code-16 on an operator key; enter goes to WR_OP only if an opcode has been latched, otherwise it is ignored.
REQ-013 SHALL, on recall in NUM1, set op1 = last result and go directly to WR1 without conversion; the last result is 0 after reset.
REQ-014 SHALL, on clear in NUM1, OPSEL or NUM2, go to NUM1 and zero the buffers, counts and opcode.
REQ-015 SHALL, in RUN, drive cpu_en=1, fpga_en=0, fpga_write=0 and address=ADDR_IDLE; keys are ignored.
REQ-016 SHALL leave RUN for FETCH when instruction == DONE_INSTR, including on the first RUN cycle.
REQ-017 SHALL, in FETCH, drive address=ADDR_RES for one cycle, latch data_in into the result register, then go to DISPLAY.
REQ-018 SHALL, in DISPLAY, set disp = result[4*DIGITS-1:0] (hex nibbles), set ovf=1 if any higher bit is set, and hold nrst_fpga=0; enter goes to NUM1.
REQ-019 SHALL, in all states other than RUN, drive fpga_en=1 and cpu_en=0.
REQ-020 SHALL, outside the WRx states, drive fpga_write=0, data_out=0 and address=ADDR_IDLE, except address=ADDR_RES in FETCH and DISPLAY.
REQ-021 SHALL ignore key_valid arriving in the same cycle as a state exit (no double consumption).

Reset
REQ-022 SHALL, on nrst low, take effect immediately from any state including RUN: state=NUM1, and all buffers, counts, opcode, result and ovf cleared.
REQ-023 SHALL hold these output values during reset: cpu_en=0, fpga_en=1, fpga_write=0, nrst_fpga=1, address=ADDR_IDLE, data_out=0, disp=0, disp_sel=0, busy=0.

Structure
REQ-024 SHALL place the state enum, the key-code constants and the opcode enum in shared package calc_pkg.
REQ-025 SHALL implement the serial BCD-to-binary accumulator as sub-module bcd_serial_conv (start, digit in, done, 32-bit out).

Verification
REQ-026 SHALL cover: keys 1,2,3,enter with DIGITS=4 -> write of 123 to address 220 exactly 4 cycles after CONV1 entry.
REQ-027 SHALL cover: keys 9,9,9,9,5 -> buffer 9999, key 5 ignored; backspace x5 -> count 0, no underflow.
REQ-028 SHALL cover: full flow 7, +, 5 with DONE_INSTR arriving 10 cycles later -> 260 written with 0, 240 written with 5, cpu_en high 10 cycles, result data_in=12 displayed as 0x000C.
REQ-029 SHALL cover: data_in=32'h0001_0000 in FETCH -> disp=0, ovf=1; recall in next NUM1 -> 220 written with 32'h0001_0000.
REQ-030 SHALL cover: nrst asserted mid-RUN -> cpu_en=0 and state=NUM1 immediately; clear in NUM2 -> NUM1 with empty buffers.
